// File: rtl/fp_pkg.sv
// Shared constants and types for the pipelined floating-point multiplier.
package fp_pkg;

    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    function automatic int fp_bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
    endfunction

    function automatic int fp_emax(input int exp_w);
        return (32'sd1 <<< exp_w) - 32'sd1;
    endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Combinational final stage: normalise the raw product, round, range-check and pack.
// Flag outputs exist only when FP_MUL_FLAGS_EN is defined.
module fp_mul_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    sign,
    input  logic signed [EXP_W+1:0] exp_sum,
    input  logic [2*MAN_W+1:0]      prod,
    input  fp_class_e               cls,
    input  logic                    rm,
`ifdef FP_MUL_FLAGS_EN
    output logic [3:0]              flags,
`endif
    output logic [EXP_W+MAN_W:0]    p
);

    localparam int PW = 2*MAN_W + 2;
    localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'(fp_emax(EXP_W));
    localparam logic signed [EXP_W+1:0] ZERO_S = '0;

    logic [PW-2:0]           norm_s;
    logic [MAN_W-1:0]        frac_raw_s;
    logic                    guard_s;
    logic                    sticky_s;
    logic                    inc_s;
    logic [MAN_W:0]          rnd_s;
    logic [MAN_W-1:0]        frac_s;
    logic signed [EXP_W+1:0] exp_s;
    logic                    ovf_s;
    logic                    unf_s;

    // Normalise (hidden bit dropped), round, then select special/overflow/underflow/normal packing
    always_comb begin
        norm_s     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        frac_raw_s = norm_s[PW-2:MAN_W+1];
        guard_s    = norm_s[MAN_W];
        sticky_s   = |norm_s[MAN_W-1:0];
        inc_s      = (rm == RM_RNE) && guard_s && (sticky_s || frac_raw_s[0]);
        rnd_s      = {1'b0, frac_raw_s} + {{MAN_W{1'b0}}, inc_s};
        frac_s     = rnd_s[MAN_W] ? {MAN_W{1'b0}} : rnd_s[MAN_W-1:0];
        exp_s      = exp_sum + $signed({{(EXP_W+1){1'b0}}, prod[PW-1]})
                             + $signed({{(EXP_W+1){1'b0}}, rnd_s[MAN_W]});
        ovf_s      = (cls == FP_NORM) && (exp_s >= EMAX_S);
        unf_s      = (cls == FP_NORM) && (exp_s <= ZERO_S);
        case (cls)
            FP_NAN:  p = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            FP_INF:  p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            FP_ZERO: p = {sign, {(EXP_W+MAN_W){1'b0}}};
            default: begin
                if (ovf_s) begin
                    if (rm == RM_RNE) begin
                        p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else begin
                        p = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    end
                end else if (unf_s) begin
                    p = {sign, {(EXP_W+MAN_W){1'b0}}};
                end else begin
                    p = {sign, exp_s[EXP_W-1:0], frac_s};
                end
            end
        endcase
`ifdef FP_MUL_FLAGS_EN
        flags                 = 4'b0000;
        flags[FLAG_INVALID]   = (cls == FP_NAN);
        flags[FLAG_OVERFLOW]  = ovf_s;
        flags[FLAG_UNDERFLOW] = unf_s;
        flags[FLAG_INEXACT]   = ovf_s || unf_s || ((cls == FP_NORM) && (guard_s || sticky_s));
`endif
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake and global stall.
// Defining FP_MUL_FLAGS_EN adds the out_flags {invalid, overflow, underflow, inexact} port.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef FP_MUL_FLAGS_EN
    output logic [3:0]           out_flags,
`endif
    output logic [EXP_W+MAN_W:0] out_p
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2*MAN_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS_S   = (EXP_W+2)'(fp_bias(EXP_W));
    localparam logic [EXP_W-1:0]        EXP_ONES = '1;

    logic                    advance_s;
    fp_class_e               cls_a_s, cls_b_s;
    logic                    s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q, s1_rm_d, s1_rm_q;
    logic signed [EXP_W+1:0] s1_exp_d, s1_exp_q;
    logic [MAN_W:0]          s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;
    fp_class_e               s1_cls_d, s1_cls_q;
    logic                    s2_valid_d, s2_valid_q, s2_sign_d, s2_sign_q, s2_rm_d, s2_rm_q;
    logic signed [EXP_W+1:0] s2_exp_d, s2_exp_q;
    logic [PW-1:0]           s2_prod_d, s2_prod_q;
    fp_class_e               s2_cls_d, s2_cls_q;
    logic                    out_valid_d, out_valid_q;
    logic [W-1:0]            out_p_d, out_p_q, p_s;
`ifdef FP_MUL_FLAGS_EN
    logic [3:0]              flags_s, out_flags_d, out_flags_q;
`endif

    assign advance_s = ~out_valid_q | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
`ifdef FP_MUL_FLAGS_EN
    assign out_flags = out_flags_q;
`endif

    function automatic fp_class_e classify(input logic [W-1:0] x);
        fp_class_e c;
        if (x[W-2:MAN_W] == {EXP_W{1'b0}}) begin
            c = FP_ZERO;
        end else if (x[W-2:MAN_W] == EXP_ONES) begin
            c = (x[MAN_W-1:0] == {MAN_W{1'b0}}) ? FP_INF : FP_NAN;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

    // S1: unpack, classify, exponent sum, precomputed special result
    always_comb begin
        cls_a_s    = classify(in_a);
        cls_b_s    = classify(in_b);
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_ma_d    = s1_ma_q;
        s1_mb_d    = s1_mb_q;
        s1_cls_d   = s1_cls_q;
        s1_rm_d    = s1_rm_q;
        if (advance_s) begin
            s1_valid_d = in_valid;
            s1_sign_d  = in_a[W-1] ^ in_b[W-1];
            s1_exp_d   = $signed({2'b00, in_a[W-2:MAN_W]}) + $signed({2'b00, in_b[W-2:MAN_W]}) - BIAS_S;
            s1_ma_d    = {1'b1, in_a[MAN_W-1:0]};
            s1_mb_d    = {1'b1, in_b[MAN_W-1:0]};
            s1_rm_d    = in_rm;
            if ((cls_a_s == FP_NAN) || (cls_b_s == FP_NAN) ||
                ((cls_a_s == FP_INF) && (cls_b_s == FP_ZERO)) ||
                ((cls_a_s == FP_ZERO) && (cls_b_s == FP_INF))) begin
                s1_cls_d = FP_NAN;
            end else if ((cls_a_s == FP_INF) || (cls_b_s == FP_INF)) begin
                s1_cls_d = FP_INF;
            end else if ((cls_a_s == FP_ZERO) || (cls_b_s == FP_ZERO)) begin
                s1_cls_d = FP_ZERO;
            end else begin
                s1_cls_d = FP_NORM;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2: full-width mantissa product
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_prod_d  = s2_prod_q;
        s2_cls_d   = s2_cls_q;
        s2_rm_d    = s2_rm_q;
        if (advance_s) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_sign_q;
            s2_exp_d   = s1_exp_q;
            s2_prod_d  = PW'(s1_ma_q) * PW'(s1_mb_q);
            s2_cls_d   = s1_cls_q;
            s2_rm_d    = s1_rm_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    fp_mul_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .sign    (s2_sign_q),
        .exp_sum (s2_exp_q),
        .prod    (s2_prod_q),
        .cls     (s2_cls_q),
        .rm      (s2_rm_q),
`ifdef FP_MUL_FLAGS_EN
        .flags   (flags_s),
`endif
        .p       (p_s)
    );

    // S3: capture the packed result into the output register
    always_comb begin
        if (advance_s) begin
            out_valid_d = s2_valid_q;
            out_p_d     = p_s;
        end else begin
            out_valid_d = out_valid_q;
            out_p_d     = out_p_q;
        end
`ifdef FP_MUL_FLAGS_EN
        out_flags_d = advance_s ? flags_s : out_flags_q;
`endif
    end

    // Pipeline registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s1_cls_q    <= FP_ZERO;
            s1_rm_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_cls_q    <= FP_ZERO;
            s2_rm_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
`ifdef FP_MUL_FLAGS_EN
            out_flags_q <= 4'b0000;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s1_cls_q    <= s1_cls_d;
            s1_rm_q     <= s1_rm_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s2_cls_q    <= s2_cls_d;
            s2_rm_q     <= s2_rm_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
`ifdef FP_MUL_FLAGS_EN
            out_flags_q <= out_flags_d;
`endif
        end
    end

endmodule
